// File: rtl/sonar_scheduler.sv
// Round-robin trigger/echo sequencer for N ultrasonic sensors sharing one pulse-width measurement block.
// Optional feature macro SONAR_AVG_EN: normal results are averaged with the sensor's previous reading.
module sonar_scheduler #(
    parameter int N_SENSORS  = 2,
    parameter int TRIG_US    = 10,
    parameter int TIMEOUT_US = 30000,
    parameter int PERIOD_US  = 60000,
    parameter int SETTLE     = 4,
    localparam int IDW       = (N_SENSORS > 2) ? $clog2(N_SENSORS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [N_SENSORS-1:0]    echo_in,
    input  logic [19:0]             meas_dist,
    output logic [N_SENSORS-1:0]    trig_out,
    output logic                    echo_mux,
    output logic [IDW-1:0]          cur_id,
    output logic                    dist_valid,
    output logic [IDW-1:0]          dist_id,
    output logic [19:0]             dist_cm,
    output logic                    dist_timeout,
    output logic [20*N_SENSORS-1:0] dist_bank,
    output logic                    busy
);
    localparam int TW = 20;
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [N_SENSORS-1:0] ONE = N_SENSORS'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_TRIG, S_WAIT_RISE, S_WAIT_FALL, S_SETTLE, S_GAP
    } state_t;

    state_t          state, state_n;
    logic [IDW-1:0]  idx, idx_n;
    logic [TW-1:0]   timer;
    logic [SW-1:0]   settle_cnt;
    logic            sync1, sync2, echo_dly;
    logic            rise, fall, timed_out, timer_clr;
    logic            wr_normal, wr_timeout;
    logic [19:0]     norm_value, wr_value;
    logic [19:0]     bank [N_SENSORS];

    assign rise      = sync2 & ~echo_dly;
    assign fall      = ~sync2 & echo_dly;
    // Decided one cycle early so the registered strobe lands when the timer reads TIMEOUT_US.
    assign timed_out = timer >= TW'(TIMEOUT_US - 1);
    assign wr_value  = wr_timeout ? 20'hFFFFF : norm_value;
    assign cur_id    = idx;
    assign busy      = (state != S_IDLE);
    assign echo_mux  = (state == S_WAIT_RISE || state == S_WAIT_FALL || state == S_SETTLE)
                       ? echo_in[idx] : 1'b0;

    for (genvar k = 0; k < N_SENSORS; k++) begin : g_bank
        assign dist_bank[k*20 +: 20] = bank[k];
    end

`ifdef SONAR_AVG_EN
    logic [N_SENSORS-1:0] hist;
    logic [19:0]          avg;
    assign avg        = 20'(({1'b0, bank[idx]} + {1'b0, meas_dist}) >> 1);
    assign norm_value = hist[idx] ? avg : meas_dist;

    always_ff @(posedge clk) begin
        if (rst)             hist      <= '0;
        else if (wr_normal)  hist[idx] <= 1'b1;
        else if (wr_timeout) hist[idx] <= 1'b0;
    end
`else
    assign norm_value = meas_dist;
`endif

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_n    = state;
        idx_n      = idx;
        timer_clr  = 1'b0;
        wr_normal  = 1'b0;
        wr_timeout = 1'b0;
        case (state)
            S_IDLE: if (enable) begin
                state_n   = S_TRIG;
                timer_clr = 1'b1;
            end
            S_TRIG: if (timer >= TW'(TRIG_US - 1)) state_n = S_WAIT_RISE;
            S_WAIT_RISE: begin
                if (timed_out) begin
                    wr_timeout = 1'b1;
                    state_n    = S_GAP;
                end else if (rise) begin
                    state_n = S_WAIT_FALL;
                end
            end
            S_WAIT_FALL: begin
                if (timed_out) begin
                    wr_timeout = 1'b1;
                    state_n    = S_GAP;
                end else if (fall) begin
                    state_n = S_SETTLE;
                end
            end
            S_SETTLE: if (settle_cnt == SW'(SETTLE - 1)) begin
                wr_normal = 1'b1;
                state_n   = S_GAP;
            end
            S_GAP: if (timer >= TW'(PERIOD_US - 1)) begin
                idx_n = (idx == IDW'(N_SENSORS - 1)) ? '0 : idx + 1'b1;
                if (enable) begin
                    state_n   = S_TRIG;
                    timer_clr = 1'b1;
                end else begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            idx          <= '0;
            timer        <= '0;
            settle_cnt   <= '0;
            sync1        <= 1'b0;
            sync2        <= 1'b0;
            echo_dly     <= 1'b0;
            trig_out     <= '0;
            dist_valid   <= 1'b0;
            dist_id      <= '0;
            dist_cm      <= '0;
            dist_timeout <= 1'b0;
            // NOTE: the result bank is reset explicitly because it is visible at the ports.
            for (int k = 0; k < N_SENSORS; k++) bank[k] <= '0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            settle_cnt <= (state == S_SETTLE) ? settle_cnt + 1'b1 : '0;
            if (timer_clr)       timer <= '0;
            else if (timer != '1) timer <= timer + 1'b1;

            // Switching sensors flushes the synchronizer so the new line shows no edge.
            if (idx_n != idx) begin
                sync1    <= 1'b0;
                sync2    <= 1'b0;
                echo_dly <= 1'b0;
            end else begin
                sync1    <= echo_in[idx];
                sync2    <= sync1;
                echo_dly <= sync2;
            end

            trig_out   <= (state_n == S_TRIG) ? (ONE << idx_n) : '0;
            dist_valid <= wr_normal | wr_timeout;
            if (wr_normal || wr_timeout) begin
                dist_id      <= idx;
                dist_cm      <= wr_value;
                dist_timeout <= wr_timeout;
                bank[idx]    <= wr_value;
            end
        end
    end
endmodule

// File: tb/tb_sonar_scheduler.sv
// Directed bench for sonar_scheduler: scoreboard of expected slot results plus timing/reset checks.
// Honors SONAR_AVG_EN the same way as the design.
module tb_sonar_scheduler;
    localparam int N = 2, TRIG = 10, TMO = 300, PER = 400, SET = 4;
`ifdef SONAR_AVG_EN
    localparam logic [19:0] SECOND_READING = 20'd150;
`else
    localparam logic [19:0] SECOND_READING = 20'd200;
`endif

    logic        clk = 1'b0, rst = 1'b1, enable = 1'b0;
    logic [1:0]  echo_in = '0;
    logic [19:0] meas_dist = '0;
    logic [1:0]  trig_out;
    logic        echo_mux, dist_valid, dist_timeout, busy;
    logic [0:0]  cur_id, dist_id;
    logic [19:0] dist_cm;
    logic [39:0] dist_bank;

    typedef struct packed { logic [0:0] id; logic [19:0] cm; logic tmo; } exp_t;
    exp_t sb[$];
    int vectors = 0, miscompares = 0, cyc = 0, slot_start = 0;
    logic trig_seen;

    sonar_scheduler #(.N_SENSORS(N), .TRIG_US(TRIG), .TIMEOUT_US(TMO),
                      .PERIOD_US(PER), .SETTLE(SET)) dut (
        .clk(clk), .rst(rst), .enable(enable), .echo_in(echo_in), .meas_dist(meas_dist),
        .trig_out(trig_out), .echo_mux(echo_mux), .cur_id(cur_id), .dist_valid(dist_valid),
        .dist_id(dist_id), .dist_cm(dist_cm), .dist_timeout(dist_timeout),
        .dist_bank(dist_bank), .busy(busy));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_result(input logic [0:0] id, input logic [19:0] cm, input logic tmo);
        sb.push_back(exp_t'{id, cm, tmo});
    endtask

    task automatic at_timer(input int t);
        while (cyc - slot_start < t) @(negedge clk);
    endtask

    task automatic wait_trig(input string tag, input logic [1:0] exp_trig, input int exp_start);
        int n = 0;
        while (trig_out === 2'b00 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_seen"}, 64'(trig_out !== 2'b00), 64'(1));
        check({tag, "_onehot"}, 64'(trig_out), 64'(exp_trig));
        check({tag, "_start"}, 64'(cyc), 64'(exp_start));
        slot_start = cyc;
    endtask

    // Scoreboard: every strobe must match the oldest pending expectation.
    always @(negedge clk) begin
        exp_t e;
        if (cyc > 0 && dist_valid !== 1'b0) begin
            if (sb.size() == 0) begin
                check("unexpected_strobe", 64'(dist_valid), 64'(0));
            end else begin
                e = sb.pop_front();
                check("sb_id", 64'(dist_id), 64'(e.id));
                check("sb_cm", 64'(dist_cm), 64'(e.cm));
                check("sb_timeout", 64'(dist_timeout), 64'(e.tmo));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_trig", 64'(trig_out), 64'(0));
        check("rst_echo_mux", 64'(echo_mux), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_valid", 64'(dist_valid), 64'(0));
        check("rst_cm", 64'(dist_cm), 64'(0));
        check("rst_bank", 64'(dist_bank), 64'(0));
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_busy", 64'(busy), 64'(0));
        check("idle_trig", 64'(trig_out), 64'(0));

        // Scenario 1: enable starts a trigger on sensor 0 the next cycle, 10 cycles wide.
        enable = 1'b1;
        wait_trig("s1", 2'b01, cyc + 1);
        check("s1_busy", 64'(busy), 64'(1));
        for (int i = 0; i < TRIG; i++) begin
            at_timer(i);
            check("s1_trig_hi", 64'(trig_out), 64'(2'b01));
        end
        at_timer(TRIG);
        check("s1_trig_lo", 64'(trig_out), 64'(0));

        // Scenario 2: normal echo on sensor 0.
        at_timer(50);
        echo_in[0] = 1'b1;
        meas_dist  = 20'd1234;
        expect_result(1'b0, 20'd1234, 1'b0);
        at_timer(60);
        check("s2_echo_mux", 64'(echo_mux), 64'(1));
        check("s2_cur_id", 64'(cur_id), 64'(0));
        at_timer(150);
        echo_in[0] = 1'b0;
        at_timer(200);
        check("s2_bank0", 64'(dist_bank[19:0]), 64'(1234));
        check("s2_hold_cm", 64'(dist_cm), 64'(1234));
        check("s2_sb_drained", 64'(sb.size()), 64'(0));

        // Scenario 3: sensor 1 never echoes; timeout strobe at timer 300, next slot 400 later.
        expect_result(1'b1, 20'hFFFFF, 1'b1);
        wait_trig("s3", 2'b10, slot_start + PER);
        at_timer(TMO - 1);
        check("s3_not_early", 64'(dist_valid), 64'(0));
        at_timer(TMO);
        check("s3_strobe", 64'(dist_valid), 64'(1));
        check("s3_cur_id", 64'(cur_id), 64'(1));
        wait_trig("s3_next", 2'b01, slot_start + PER);

        // Scenario 4: echo stuck high past the timeout on sensor 0.
        at_timer(20);
        echo_in[0] = 1'b1;
        meas_dist  = 20'd777;
        expect_result(1'b0, 20'hFFFFF, 1'b1);
        at_timer(TMO - 1);
        check("s4_mux_before", 64'(echo_mux), 64'(1));
        at_timer(TMO);
        check("s4_mux_forced", 64'(echo_mux), 64'(0));
        check("s4_strobe", 64'(dist_valid), 64'(1));
        at_timer(TMO + 20);
        echo_in[0] = 1'b0;
        check("s4_bank0", 64'(dist_bank[19:0]), 64'(20'hFFFFF));
        check("s4_bank1", 64'(dist_bank[39:20]), 64'(20'hFFFFF));

        // Scenario 5: enable drops during WAIT_FALL; slot finishes, then IDLE.
        wait_trig("s5", 2'b10, slot_start + PER);
        at_timer(30);
        echo_in[1] = 1'b1;
        meas_dist  = 20'd4321;
        expect_result(1'b1, 20'd4321, 1'b0);
        at_timer(60);
        enable = 1'b0;
        at_timer(90);
        echo_in[1] = 1'b0;
        at_timer(PER - 1);
        check("s5_busy_gap", 64'(busy), 64'(1));
        check("s5_bank1", 64'(dist_bank[39:20]), 64'(4321));
        check("s5_sb_drained", 64'(sb.size()), 64'(0));
        at_timer(PER);
        check("s5_idle_busy", 64'(busy), 64'(0));
        check("s5_idle_trig", 64'(trig_out), 64'(0));
        check("s5_wrap_id", 64'(cur_id), 64'(0));
        trig_seen = 1'b0;
        repeat (450) begin
            @(negedge clk);
            if (trig_out !== 2'b00 || busy !== 1'b0) trig_seen = 1'b1;
        end
        check("s5_stays_idle", 64'(trig_seen), 64'(0));

        // Scenario 6: readings 100 then 200 on sensor 0, then reset mid-slot.
        enable = 1'b1;
        wait_trig("s6a", 2'b01, cyc + 1);
        at_timer(50);
        echo_in[0] = 1'b1;
        meas_dist  = 20'd100;
        expect_result(1'b0, 20'd100, 1'b0);
        at_timer(150);
        echo_in[0] = 1'b0;
        at_timer(200);
        check("s6_bank0_first", 64'(dist_bank[19:0]), 64'(100));
        expect_result(1'b1, 20'hFFFFF, 1'b1);
        wait_trig("s6b", 2'b10, slot_start + PER);
        at_timer(TMO + 10);
        check("s6_bank1_tmo", 64'(dist_bank[39:20]), 64'(20'hFFFFF));
        wait_trig("s6c", 2'b01, slot_start + PER);
        at_timer(50);
        echo_in[0] = 1'b1;
        meas_dist  = 20'd200;
        expect_result(1'b0, SECOND_READING, 1'b0);
        at_timer(150);
        echo_in[0] = 1'b0;
        at_timer(200);
        check("s6_bank0_second", 64'(dist_bank[19:0]), 64'(SECOND_READING));
        check("s6_cm_second", 64'(dist_cm), 64'(SECOND_READING));
        wait_trig("s6d", 2'b10, slot_start + PER);
        at_timer(20);
        echo_in[1] = 1'b1;
        meas_dist  = 20'd999;
        at_timer(40);
        rst    = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        check("mid_rst_trig", 64'(trig_out), 64'(0));
        check("mid_rst_mux", 64'(echo_mux), 64'(0));
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_valid", 64'(dist_valid), 64'(0));
        check("mid_rst_id", 64'(dist_id), 64'(0));
        check("mid_rst_cm", 64'(dist_cm), 64'(0));
        check("mid_rst_tmo", 64'(dist_timeout), 64'(0));
        check("mid_rst_bank", 64'(dist_bank), 64'(0));
        check("mid_rst_cur_id", 64'(cur_id), 64'(0));
        rst        = 1'b0;
        echo_in[1] = 1'b0;
        repeat (100) @(negedge clk);
        check("end_busy", 64'(busy), 64'(0));
        check("end_sb_empty", 64'(sb.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/sonar_scheduler.md
Name: sonar_scheduler

Overview:
- Round-robin sequencer for N ultrasonic sensors that share one echo pulse-width measurement block.
- Per slot: fires a trigger pulse, routes the selected sensor's echo to the measurement block, waits for the echo or a timeout, then captures the result.
- Stores the latest distance per sensor and enforces a minimum slot period so ringing does not cross between sensors.
- Runs on the 1 MHz system tick (1 cycle = 1 us).

Parameters:
- N_SENSORS, 2, number of sensors (2..8); IDW = clog2(N_SENSORS), minimum 1.
- TRIG_US, 10, trigger pulse width in cycles.
- TIMEOUT_US, 30000, cycles from trigger start until the slot is declared a timeout.
- PERIOD_US, 60000, minimum cycles from one trigger start to the next; must exceed TIMEOUT_US + SETTLE + 2.
- SETTLE, 4, cycles waited after the echo falling edge before sampling meas_dist.

Ports:
- clk  in  1  1 MHz clock.
- rst  in  1  synchronous reset, active-high.
- enable  in  1  run the measurement sequence.
- echo_in  in  N_SENSORS  raw echo lines, asynchronous.
- meas_dist  in  20  distance (cm) from the measurement block.
- trig_out  out  N_SENSORS  trigger lines, one-hot or zero, registered.
- echo_mux  out  1  echo routed to the measurement block.
- cur_id  out  IDW  sensor index of the current slot.
- dist_valid  out  1  one-cycle strobe when a slot result is written.
- dist_id  out  IDW  sensor index of that result.
- dist_cm  out  20  result value.
- dist_timeout  out  1  result is a timeout; qualified by dist_valid.
- dist_bank  out  20*N_SENSORS  latest result per sensor; sensor k occupies bits [20k+19:20k].
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (all registers, takes effect the cycle after rst is sampled high):
  - State IDLE, idx 0, slot timer 0.
  - trig_out 0, echo_mux 0, dist_valid 0, dist_cm 0, dist_timeout 0, dist_bank all 0, busy 0.
  - Echo synchronizer flops cleared.
  - Reset mid-slot aborts immediately; there is no final strobe.
- Echo handling:
  - echo_in[idx] passes through a 2-flop synchronizer, then a delay flop.
  - Rise = synced 1 and delayed 0. Fall = synced 0 and delayed 1.
  - On idx change, the synchronizer is cleared so no edge is seen.
- Slot timer:
  - Cleared on entry to TRIG, increments every cycle after that.
  - 20 bits, saturating.
- State machine:
  - IDLE: enable=1 -> TRIG. enable sampled at cycle t gives trig_out[idx]=1 at t+1.
  - TRIG: trig_out[idx]=1 for exactly TRIG_US cycles -> WAIT_RISE.
  - WAIT_RISE:
    - rise -> WAIT_FALL.
    - timer reaches TIMEOUT_US -> timeout result -> GAP.
  - WAIT_FALL:
    - fall -> SETTLE.
    - timeout -> timeout result -> GAP.
  - SETTLE: after SETTLE cycles, capture meas_dist as a normal result -> GAP.
  - GAP:
    - Wait until timer reaches PERIOD_US-1.
    - Then idx <= (idx == N_SENSORS-1) ? 0 : idx+1.
    - Next state: TRIG if enable=1, else IDLE.
- echo_mux:
  - Equals raw echo_in[idx] in WAIT_RISE, WAIT_FALL and SETTLE; 0 in all other states.
  - An echo still high at timeout is forced low, and its stale measurement is discarded.
- Result write, one cycle:
  - dist_valid=1, dist_id=idx.
  - Normal result: dist_cm=meas_dist, dist_timeout=0.
  - Timeout result: dist_cm=20'hFFFFF, dist_timeout=1.
  - The same value is written into dist_bank[idx].
  - dist_cm, dist_id and dist_timeout hold their values until the next write.
- Simultaneous events:
  - Rise or fall in the same cycle the timer reaches TIMEOUT_US: the timeout wins.
  - enable dropping mid-slot: the slot completes, including its result and GAP, then the block returns to IDLE.
- Rise during TRIG is ignored; the block waits for a fresh rise in WAIT_RISE.
- Sensor order is strictly 0,1,...,N-1,0; there is no skipping.

Optional Feature:
- SONAR_AVG_EN defined:
  - A normal result writes dist_bank[idx] = (old + new) >> 1, using 21-bit intermediate arithmetic.
  - Exception: the first normal result after reset, or after a timeout for that sensor, is stored directly.
  - dist_cm on the strobe carries the averaged value.
  - Timeouts are stored unaveraged as 20'hFFFFF.
- SONAR_AVG_EN undefined: raw value written; no per-sensor history flags are built.

Test Plan:
- Bench parameters: N=2, TRIG_US=10, TIMEOUT_US=300, PERIOD_US=400, SETTLE=4.
- Scenario 1: reset, enable=1 at t0 -> trig_out=2'b01 for cycles t0+1..t0+10; busy=1 from t0+1.
- Scenario 2: echo_in[0] high 100 cycles starting 50 after trigger, meas_dist=1234 -> one dist_valid with dist_id=0, dist_cm=1234, dist_timeout=0; dist_bank[19:0]=1234.
- Scenario 3: echo_in[1] never rises -> at timer 300: dist_valid, dist_id=1, dist_cm=20'hFFFFF, dist_timeout=1. Next trigger is on sensor 0, 400 cycles after the previous trigger start.
- Scenario 4: echo stuck high past the timeout -> timeout result; echo_mux drops to 0 at the timeout; no normal result for that slot.
- Scenario 5: enable drops during WAIT_FALL -> the result is still written, GAP completes, then IDLE with busy=0 and no further trigger.
- Scenario 6: SONAR_AVG_EN with readings 100 then 200 on sensor 0 -> dist_bank[19:0]=100, then 150. Assert rst mid-slot -> all outputs 0 the next cycle.
